// File: rtl/aes_pkg.sv
// Shared AES constants, key-schedule state encoding and GF(2^8) helpers.
package aes_pkg;

    localparam int unsigned AES_KEY_W      = 128;
    localparam int unsigned AES_NUM_ROUNDS = 10;
    localparam logic [7:0]  RCON_INIT      = 8'h01;
    localparam logic [7:0]  RCON_POLY      = 8'h1b;

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } ks_state_e;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

    // General GF(2^8) multiply built from shift-and-add with xtime.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ aa;
            end
            aa = xtime(aa);
        end
        return acc;
    endfunction

endpackage

// File: rtl/calc_key.sv
// Combinational single-round AES-128 key step on a row-major 128-bit key.
module calc_key
    import aes_pkg::*;
(
    input  logic [127:0] prev_key,
    input  logic [31:0]  rcon_val,
    output logic [127:0] next_key
);

    // S-box as multiplicative inverse (x^254) followed by the AES affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        // x^254 = x^2 * x^4 * ... * x^128
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic [31:0] w [4];
    logic [31:0] n [4];
    logic [31:0] rot;
    logic [31:0] sub;

    // Unpack columns, apply RotWord/SubWord/Rcon, chain the XORs, repack.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            w[c] = '0;
            for (int r = 0; r < 4; r++) begin
                w[c][31-8*r -: 8] = prev_key[127-32*r-8*c -: 8];
            end
        end
        rot  = {w[3][23:0], w[3][31:24]};
        sub  = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
        n[0] = w[0] ^ sub ^ rcon_val;
        n[1] = n[0] ^ w[1];
        n[2] = n[1] ^ w[2];
        n[3] = n[2] ^ w[3];
        next_key = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                next_key[127-32*r-8*c -: 8] = n[c][31-8*r -: 8];
            end
        end
    end

endmodule

// File: rtl/key_schedule.sv
// Sequential AES-128 key expansion: one round per clock, 11 stored round keys
// with a registered read port.
module key_schedule
    import aes_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = AES_NUM_ROUNDS,
    parameter int unsigned IDX_W      = 4
) (
    input  logic                 pi_clk,
    input  logic                 pi_rst_n,
    input  logic                 pi_start,
    input  logic [127:0]         pi_key,
    input  logic [IDX_W-1:0]     pi_rd_idx,
    output logic                 po_busy,
    output logic                 po_done,
    output logic                 po_keys_valid,
    output logic [127:0]         po_rd_key
);

    ks_state_e            state_q, state_d;
    logic [IDX_W-1:0]     round_q, round_d;
    logic [7:0]           rcon_q, rcon_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 valid_q, valid_d;
    logic                 load_key;
    logic                 write_key;
    logic [127:0]         rk_q [NUM_ROUNDS+1];
    logic [127:0]         prev_key;
    logic [127:0]         next_key;
    logic [127:0]         rd_key_q, rd_key_d;

    // Select rk[round-1] as the key step input; zero when no round is active.
    always_comb begin
        prev_key = '0;
        for (int i = 1; i <= int'(NUM_ROUNDS); i++) begin
            if (round_q == IDX_W'(i)) begin
                prev_key = rk_q[i-1];
            end
        end
    end

    calc_key u_calc_key (
        .prev_key (prev_key),
        .rcon_val ({rcon_q, 24'h0}),
        .next_key (next_key)
    );

    // FSM state register.
    always_ff @(posedge pi_clk or negedge pi_rst_n) begin
        if (!pi_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, counter, Rcon and status decode.
    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        rcon_d    = rcon_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        valid_d   = valid_q;
        load_key  = 1'b0;
        write_key = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pi_start) begin
                    load_key = 1'b1;
                    round_d  = IDX_W'(1);
                    rcon_d   = RCON_INIT;
                    busy_d   = 1'b1;
                    valid_d  = 1'b0;
                    state_d  = EXPAND;
                end
            end
            EXPAND: begin
                // pi_start is deliberately ignored here.
                write_key = 1'b1;
                rcon_d    = xtime(rcon_q);
                if (round_q == IDX_W'(NUM_ROUNDS)) begin
                    done_d  = 1'b1;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    round_d = '0;
                    state_d = IDLE;
                end else begin
                    round_d = round_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and status registers.
    always_ff @(posedge pi_clk or negedge pi_rst_n) begin
        if (!pi_rst_n) begin
            round_q <= '0;
            rcon_q  <= RCON_INIT;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            round_q <= round_d;
            rcon_q  <= rcon_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
        end
    end

    // Round-key register file: slot 0 takes the cipher key, slots 1..10 the key step.
    always_ff @(posedge pi_clk or negedge pi_rst_n) begin
        if (!pi_rst_n) begin
            for (int i = 0; i <= int'(NUM_ROUNDS); i++) begin
                rk_q[i] <= '0;
            end
        end else begin
            if (load_key) begin
                rk_q[0] <= pi_key;
            end
            for (int i = 1; i <= int'(NUM_ROUNDS); i++) begin
                if (write_key && (round_q == IDX_W'(i))) begin
                    rk_q[i] <= next_key;
                end
            end
        end
    end

    // Read mux; out-of-range indices return zero.
    always_comb begin
        rd_key_d = '0;
        for (int i = 0; i <= int'(NUM_ROUNDS); i++) begin
            if (pi_rd_idx == IDX_W'(i)) begin
                rd_key_d = rk_q[i];
            end
        end
    end

    // Registered read port, active in every state.
    always_ff @(posedge pi_clk or negedge pi_rst_n) begin
        if (!pi_rst_n) begin
            rd_key_q <= '0;
        end else begin
            rd_key_q <= rd_key_d;
        end
    end

    assign po_busy       = busy_q;
    assign po_done       = done_q;
    assign po_keys_valid = valid_q;
    assign po_rd_key     = rd_key_q;

endmodule

// File: doc/key_schedule.md
Name: key_schedule

Overview:
- Sequential AES-128 key-expansion controller that feeds the combinational single-round key step (calc_key) and consumes its output.
- Iterates calc_key ten times, one round per clock, generating Rcon internally.
- Stores all 11 round keys (0..10) for the cipher datapath, which reads them through a registered read port.
- Every 128-bit key uses the codebase's row-major byte layout. The byte at row r, word c sits at bits [127-32r-8c -: 8], where c=0 is AES word w0.

Parameters:
- NUM_ROUNDS, 10, number of expansion rounds (fixed for AES-128; not meant to be overridden)
- IDX_W, 4, width of round index / read address

Ports:
- pi_clk  input  1  clock, all state on rising edge
- pi_rst_n  input  1  asynchronous active-low reset
- pi_start  input  1  single-cycle request to expand pi_key
- pi_key  input  128  cipher key (round key 0), row-major layout
- pi_rd_idx  input  4  round-key read address, 0..10
- po_busy  output  1  expansion in progress
- po_done  output  1  one-cycle pulse when round key 10 is written
- po_keys_valid  output  1  all 11 stored keys are valid for the current key
- po_rd_key  output  128  registered read data for pi_rd_idx

Behaviour:
- Reset (async, pi_rst_n=0): FSM=IDLE, round counter=0, rcon=8'h01, po_busy=0, po_done=0, po_keys_valid=0, po_rd_key=0, all 11 key registers=0.
- FSM states: IDLE, EXPAND.
- IDLE with pi_start=1:
  - rk[0] <= pi_key, round <= 1, rcon <= 8'h01.
  - po_busy <= 1, po_keys_valid <= 0, go to EXPAND.
- EXPAND, every cycle:
  - calc_key is driven with prev_key = rk[round-1] and rcon_val = {rcon, 24'h0}.
  - rk[round] <= calc_key output, round <= round+1.
  - rcon <= xtime(rcon): {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00).
  - Resulting sequence: 01 02 04 08 10 20 40 80 1b 36.
- EXPAND with round==10:
  - Write rk[10] as above.
  - po_done <= 1 for exactly one cycle, po_keys_valid <= 1, po_busy <= 0, round <= 0, go to IDLE.
- Latency: start accepted in cycle T. po_done and po_keys_valid are high in cycle T+11, i.e. 10 EXPAND cycles after the T+1 entry.
- pi_start while busy: ignored; the running expansion is unaffected.
- pi_start in IDLE with po_keys_valid=1: restart. po_keys_valid drops the next cycle; old keys are overwritten progressively.
- pi_key is sampled only in the cycle start is accepted; later changes have no effect.
- Read port: po_rd_key <= rk[pi_rd_idx] on every clock, so latency is 1 cycle, independent of FSM state.
  - pi_rd_idx > 10 returns 128'h0.
  - A read during EXPAND returns the current register content. Consumers must qualify reads with po_keys_valid.
- Reset asserted mid-expansion: immediate return to reset values; po_done does not pulse.
- Only one calc_key instance; no combinational path from pi_* to po_* except through registers.

Decomposition:
- Shared package (aes_pkg) holds:
  - constants AES_KEY_W=128, AES_NUM_ROUNDS=10, RCON_INIT=8'h01, RCON_POLY=8'h1b
  - the state encoding (IDLE=1'b0, EXPAND=1'b1)
  - an xtime function, reused later by mix_columns
- Sub-module: one instance of existing calc_key. The key register file stays inline; no separate module.

Test Plan:
- FIPS-197 key 128'h2b28ab09_7eaef7cf_15d2154f_16a6883c, pulse start -> po_busy=1 for 10 cycles, po_done pulses at T+11; rd_idx=1 -> 128'ha088232a_fa54a36c_fe2c3976_17b13905; rd_idx=10 -> 128'hd0c9e1b6_14ee3f63_f9250c0c_a889c8a6; rd_idx=0 -> pi_key.
- All-zero key -> rd_idx=1 returns 128'h62626262_63636363_63636363_63636363; rcon probe shows 01,02,...,80,1b,36 in order.
- pi_start re-pulsed at cycles T+3 and T+7 during expansion -> ignored; single po_done at T+11; results identical to the first scenario.
- Reset asserted at T+5 -> outputs zero immediately; after release, a new start yields correct keys with fresh Rcon from 8'h01.
- Back-to-back: second start (zero key) one cycle after po_done -> po_keys_valid falls next cycle; rd_idx=1 later equals the zero-key round-1 value.
- rd_idx=11..15 -> po_rd_key=0; rd_idx change observed on po_rd_key exactly one cycle later.
